writeback_sequencer: RTL
========================

Name: writeback_sequencer

Overview:
- Multi-cycle control FSM for the core datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit writeback-select of the register-file input mux: 00 = ALU result, 01 = memory data, 10 = extended immediate.
- Drives register-write, memory-request, PC-write and IR-write strobes; sits between the instruction register and the datapath.

Parameters:
- OPC_W, 6, opcode field width.
- COUNT_W, 16, width of retired-instruction counter.
- MEM_TIMEOUT, 15, max wait cycles for mem_ready (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- opcode  input  OPC_W  opcode from instruction register, valid from DECODE onward.
- mem_ready  input  1  memory handshake completion, sampled while a request is held.
- mem_read  output  1  read request (instruction fetch or load).
- mem_write  output  1  store request.
- ir_write  output  1  one-cycle IR load strobe.
- pc_write  output  1  one-cycle PC increment strobe.
- reg_write  output  1  one-cycle register-file write strobe.
- wb_sel  output  2  writeback mux select.
- halted  output  1  core stopped.
- error  output  1  memory timeout occurred.
- retired_count  output  COUNT_W  instructions completed.

Behaviour:
- States:
  - FETCH: mem_read=1; on mem_ready=1, pulse ir_write and pc_write in the same cycle, then go to DECODE. Otherwise stay.
  - DECODE: 1 cycle. Classify opcode and latch wb_sel:
    - 6'h00 (ALU): wb_sel=00.
    - 6'h23 (LOAD): wb_sel=01.
    - 6'h2B (STORE): wb_sel=00, no writeback.
    - 6'h0F (IMM): wb_sel=10.
    - 6'h3F (HALT): go to HALT.
    - Any other opcode: illegal, treated as NOP, return to FETCH, not counted.
  - EXEC: 1 cycle. Then LOAD/STORE go to MEM; ALU/IMM go to WB.
  - MEM: hold mem_read (LOAD) or mem_write (STORE) until mem_ready=1. Then LOAD goes to WB; STORE goes to FETCH and increments retired_count.
  - WB: reg_write=1 for exactly 1 cycle, increment retired_count, go to FETCH.
  - HALT: halted=1; all strobes 0; stays until reset.
- Latency:
  - ALU/IMM: FETCH+DECODE+EXEC+WB = 4 cycles with zero-wait memory.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
- Handshake rules:
  - The request stays asserted until the cycle in which mem_ready=1 is sampled and deasserts the next cycle.
  - mem_ready outside FETCH/MEM is ignored.
  - mem_read and mem_write are never asserted together.
- wb_sel:
  - Registered; stable from the cycle after DECODE through WB.
  - Returns to 00 on entry to FETCH.
- retired_count wraps from all-ones to 0 without a flag.
- Reset (any state, including mid-handshake):
  - State=FETCH; all strobes=0; wb_sel=00; halted=0; error=0; retired_count=0.
  - mem_read is asserted in the first cycle after reset_n deasserts.
- Opcode changes outside DECODE have no effect.

Optional Feature:
- Macro: WB_SEQ_MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle without mem_ready.
  - When the counter reaches MEM_TIMEOUT, drop the request, set error=1 and go to HALT (halted=1).
  - mem_ready in the same cycle the counter reaches MEM_TIMEOUT wins: it is a normal completion.
- Undefined: waits indefinitely; error tied to 0; no counter logic.

Decomposition:
- Shared package contents:
  - State enum (FETCH, DECODE, EXEC, MEM, WB, HALT).
  - Opcode constants OPC_ALU, OPC_LOAD, OPC_STORE, OPC_IMM, OPC_HALT.
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_EXT=2'b10.
- Natural sub-module: wb_seq_decoder, combinational. Maps opcode to {class, wb_sel, illegal}; the FSM registers its outputs in DECODE.

Test Plan:
- ALU with mem_ready tied 1, opcode 6'h00:
  - ir_write/pc_write pulse in cycle 1 after reset.
  - reg_write=1, wb_sel=00 in cycle 4.
  - retired_count=1.
- LOAD 6'h23, mem_ready low 3 cycles in MEM:
  - mem_read held 4 cycles, then reg_write with wb_sel=01.
  - mem_write never 1.
- STORE 6'h2B then IMM 6'h0F:
  - STORE: mem_write pulse, no reg_write.
  - IMM: reg_write with wb_sel=10.
  - retired_count=2.
- Illegal 6'h15 then HALT 6'h3F:
  - Illegal: no strobes, count unchanged.
  - HALT: halted=1 and all strobes 0 for 20 cycles.
- reset_n low during MEM wait of a LOAD:
  - Outputs zero immediately (asynchronous).
  - After release, FETCH restarts; retired_count=0.
- With WB_SEQ_MEM_TIMEOUT_EN and MEM_TIMEOUT=15, mem_ready held 0 in FETCH:
  - error=1 and halted=1 after 15 cycles.
  - Repeat with mem_ready=1 on cycle 15: normal decode, error stays 0.

Source files
------------

// File: rtl/writeback_sequencer_pkg.sv
// Shared types and constants for the writeback sequencer and its opcode decoder.
package writeback_sequencer_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Instruction class produced by the decoder and latched in DECODE.
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_IMM     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_t;

  // Opcode encodings (6-bit native width).
  localparam logic [5:0] OPC_ALU   = 6'h00;
  localparam logic [5:0] OPC_LOAD  = 6'h23;
  localparam logic [5:0] OPC_STORE = 6'h2B;
  localparam logic [5:0] OPC_IMM   = 6'h0F;
  localparam logic [5:0] OPC_HALT  = 6'h3F;

  // Register-file input mux select.
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_EXT = 2'b10;

  // True for the classes that need a data-memory access after EXEC.
  function automatic logic is_mem_class(input op_class_t cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/writeback_sequencer_decoder.sv
// Combinational opcode classifier: opcode -> {class, writeback select, illegal}.
module wb_seq_decoder
  import writeback_sequencer_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        op_class,
  output logic [1:0]       wb_sel,
  output logic             illegal
);

  localparam logic [OPC_W-1:0] CODE_ALU   = OPC_W'(OPC_ALU);
  localparam logic [OPC_W-1:0] CODE_LOAD  = OPC_W'(OPC_LOAD);
  localparam logic [OPC_W-1:0] CODE_STORE = OPC_W'(OPC_STORE);
  localparam logic [OPC_W-1:0] CODE_IMM   = OPC_W'(OPC_IMM);
  localparam logic [OPC_W-1:0] CODE_HALT  = OPC_W'(OPC_HALT);

  // Classify the opcode; any encoding not listed is an illegal NOP with no writeback.
  always_comb begin
    op_class = CLS_ILLEGAL;
    wb_sel   = WB_SEL_ALU;
    illegal  = 1'b1;
    case (opcode)
      CODE_ALU: begin
        op_class = CLS_ALU;
        illegal  = 1'b0;
      end
      CODE_LOAD: begin
        op_class = CLS_LOAD;
        wb_sel   = WB_SEL_MEM;
        illegal  = 1'b0;
      end
      CODE_STORE: begin
        op_class = CLS_STORE;
        illegal  = 1'b0;
      end
      CODE_IMM: begin
        op_class = CLS_IMM;
        wb_sel   = WB_SEL_EXT;
        illegal  = 1'b0;
      end
      CODE_HALT: begin
        op_class = CLS_HALT;
        illegal  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction.
// Optional memory-handshake timeout is compiled in with WB_SEQ_MEM_TIMEOUT_EN.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         wb_sel,
  output logic               halted,
  output logic               error,
  output logic [COUNT_W-1:0] retired_count
);

  state_t             state_reg, state_next;
  op_class_t          cls_reg, cls_next;
  logic [1:0]         wb_sel_reg, wb_sel_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  // Low only in the cycle between reset release and the first clock edge, so
  // strobes stay quiet while reset is applied even though the state is FETCH.
  logic               run_reg;
  logic               timeout_hit;

  op_class_t          dec_class;
  logic [1:0]         dec_wb_sel;
  logic               dec_illegal;

  wb_seq_decoder #(
    .OPC_W(OPC_W)
  ) u_decoder (
    .opcode  (opcode),
    .op_class(dec_class),
    .wb_sel  (dec_wb_sel),
    .illegal (dec_illegal)
  );

  // State, latched instruction class, writeback select and retired counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= FETCH;
      cls_reg    <= CLS_ALU;
      wb_sel_reg <= WB_SEL_ALU;
      count_reg  <= '0;
      run_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cls_reg    <= cls_next;
      wb_sel_reg <= wb_sel_next;
      count_reg  <= count_next;
      run_reg    <= 1'b1;
    end
  end

  // Next-state and strobe decode; the opcode is only looked at in DECODE.
  always_comb begin
    state_next  = state_reg;
    cls_next    = cls_reg;
    wb_sel_next = wb_sel_reg;
    count_next  = count_reg;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    halted      = 1'b0;

    case (state_reg)
      FETCH: begin
        if (run_reg) begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = DECODE;
          end else if (timeout_hit) begin
            state_next = HALT;
          end
        end
      end
      DECODE: begin
        cls_next    = dec_class;
        wb_sel_next = dec_wb_sel;
        if (dec_class == CLS_HALT) begin
          state_next = HALT;
        end else if (dec_illegal) begin
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = is_mem_class(cls_reg) ? MEM : WB;
      end
      MEM: begin
        mem_read  = (cls_reg == CLS_LOAD);
        mem_write = (cls_reg == CLS_STORE);
        if (mem_ready) begin
          if (cls_reg == CLS_LOAD) begin
            state_next = WB;
          end else begin
            state_next = FETCH;
            count_next = count_reg + COUNT_W'(1);
          end
        end else if (timeout_hit) begin
          state_next = HALT;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        count_next = count_reg + COUNT_W'(1);
        state_next = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // Every return to FETCH restores the ALU path on the writeback mux.
    if ((state_next == FETCH) && (state_reg != FETCH)) begin
      wb_sel_next = WB_SEL_ALU;
    end
  end

  assign wb_sel        = wb_sel_reg;
  assign retired_count = count_reg;

`ifdef WB_SEQ_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_reg;
  logic              waiting;
  logic              error_reg;

  // A request is outstanding in FETCH and MEM once the sequencer is running.
  assign waiting     = run_reg && ((state_reg == FETCH) || (state_reg == MEM));
  // The last permitted cycle without mem_ready; a ready in this cycle still completes.
  assign timeout_hit = waiting && !mem_ready && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));

  // Count consecutive unanswered request cycles; any completion or state change clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_reg <= '0;
    end else if (!waiting || mem_ready) begin
      wait_reg <= '0;
    end else begin
      wait_reg <= wait_reg + WAIT_W'(1);
    end
  end

  // Sticky error flag raised alongside the move to HALT on a timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_reg <= 1'b0;
    end else if (timeout_hit) begin
      error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`else
  // Requests wait indefinitely; the threshold has no effect in this build.
  if (MEM_TIMEOUT > 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
  end else begin : g_no_timeout_any
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
  end
`endif

endmodule
